csd2bin_serial: RTL and testbench
=================================

Name: csd2bin_serial

Overview:
- Digit-serial converter from canonical signed digit (CSD) form to two's complement; it is the inverse path of the existing bin2csd converter.
- Accepts one 2-bit CSD digit per handshake, most-significant digit first.
- Uses on-the-fly conversion: Q/QM register pair, shifts only, no carry-propagate adder.
- Sits at the output of the BKM FPU digit-recurrence datapath. The MSD-first signed digits produced there are collapsed to a binary word here.

Parameters:
- W, 5, number of CSD digits per word (minimum 2).
- CW, $clog2(W+1), digit counter width (localparam, derived).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  digit present on in_digit
- in_ready  out  1  block can accept a digit this cycle
- in_digit  in  2  CSD digit: 2'b00=0, 2'b01=+1, 2'b10=-1, 2'b11=illegal
- out_valid  out  1  converted word available
- out_ready  in  1  consumer accepts the word
- out_y  out  W+1  two's complement result (range ±(2^W-1))
- out_err_ill  out  1  at least one illegal digit in this word; valid with out_valid
- out_err_ncan  out  1  two adjacent nonzero digits in this word (non-canonical); valid with out_valid

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - Outputs: out_valid=0, out_y=0, out_err_ill=0, out_err_ncan=0, in_ready=1.
  - Internals: Q=0, QM=all ones (-1), digit count=0, prev_nz=0, state=ACCUM.
  - Reset overrides every other event, including mid-word and while HOLD is pending. Any partial word is discarded.
- Digit transfer: a digit is taken when in_valid && in_ready at a rising edge.
- in_ready = (state==ACCUM) || (state==HOLD && out_ready).
- Per-digit update, all in W+1 bits with a left shift by 1:
  - d=+1: Q<=2Q+1, QM<=2Q
  - d=0: Q<=2Q, QM<=2QM+1
  - d=-1: Q<=2QM+1, QM<=2QM
  - d=illegal: treated as 0 for Q/QM and sets the sticky ill flag.
- Canonical check:
  - prev_nz holds whether the last accepted digit was nonzero.
  - A nonzero digit accepted while prev_nz=1 sets the sticky ncan flag.
  - prev_nz is cleared at the start of each word.
- States:
  - ACCUM: count digits. On accepting digit number W:
    - out_y <= next Q; out_err_* <= next sticky flags.
    - out_valid <= 1, state <= HOLD.
    - Q, QM, count, flags and prev_nz reinitialise.
  - HOLD: out_y and flags stable until out_valid && out_ready.
    - Acceptance without a new digit: out_valid <= 0, state <= ACCUM.
    - Acceptance with a new digit in the same cycle: that digit is the MSD of the next word and is processed from the init values. out_valid drops in that cycle unless W digits complete at the same time (impossible for W>=2).
- Latency and throughput:
  - out_valid rises at the edge after the cycle in which the W-th digit is accepted.
  - Sustained throughput is W digits per W cycles when out_ready=1 (no bubble).
- Stall handling:
  - in_valid=0 mid-word: state is held, no timeout.
  - out_ready=0 in HOLD: in_ready=0 and out_* held indefinitely.
- Overflow: none possible. W+1 bits cover ±(2^W-1) exactly. Shifted-out MSBs of Q/QM are redundant sign copies.

Decomposition:
- Shared header csd_defs.vh defines CSD_0=2'b00, CSD_P1=2'b01, CSD_M1=2'b10, CSD_ILL=2'b11. It is shared with bin2csd and its bench; the hard-coded defines are to be replaced by it.
- One natural sub-module: csd_otf_step. It is combinational and takes Q, QM and d to produce next Q and next QM, parameter W.
- The FSM, counter, flags and handshake live in csd2bin_serial.

Test Plan:
- W=5, digits (MSD first) 0,+1,0,-1,0 with out_ready=1 -> out_y=6'b000110 (+6), both errs=0, out_valid exactly W+1 cycles after first digit.
- Digits 0,0,-1,0,-1 -> out_y=6'b111011 (-5); then +1,0,+1,0,+1 -> 6'b010101 (+21); then -1,0,-1,0,-1 -> 6'b101011 (-21). Feed back-to-back with no idle cycles, in_ready stays 1.
- Digits +1,+1,0,0,0 -> out_y=6'b011000 (+24), out_err_ncan=1, out_err_ill=0. Next word 0,0,0,0,+1 -> +1 with both flags 0 (flags cleared per word).
- Digits 0,2'b11,0,0,+1 -> out_y=+1, out_err_ill=1.
- out_ready=0 for 7 cycles after out_valid -> in_ready=0, out_y held; then out_ready=1 together with a new digit -> digit accepted as MSD of the next word.
- Exhaustive loopback: bin2csd output for all 32 values of a 5-bit input is serialised MSD first -> out_y sign-extends the original input and out_err_ncan=0. Also assert rst after the 3rd digit -> next 5 digits form a correct fresh word.

Source files
------------

// File: rtl/csd2bin_serial_pkg.sv
// Shared definitions for the CSD-to-binary serial converter.
package csd2bin_serial_pkg;

  // CSD digit encodings, common to the bin2csd/csd2bin pair
  localparam logic [1:0] CSD_0   = 2'b00;
  localparam logic [1:0] CSD_P1  = 2'b01;
  localparam logic [1:0] CSD_M1  = 2'b10;
  localparam logic [1:0] CSD_ILL = 2'b11;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // True for the two nonzero legal digits; the illegal code counts as zero
  function automatic logic csd_is_nz(input logic [1:0] digit);
    return (digit == CSD_P1) || (digit == CSD_M1);
  endfunction

endpackage

// File: rtl/csd_otf_step.sv
// One on-the-fly conversion step: folds an MSD-first CSD digit into the Q/QM pair.
// Q holds the value so far, QM holds Q-1; neither ever needs a carry chain.
module csd_otf_step
  import csd2bin_serial_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W:0] q,
  input  logic [W:0] qm,
  input  logic [1:0] digit,
  output logic [W:0] q_next,
  output logic [W:0] qm_next
);

  // Select shifted Q or QM and append the new LSB; illegal digits act as zero
  always_comb begin
    q_next  = {q[W-1:0], 1'b0};
    qm_next = {qm[W-1:0], 1'b1};
    case (digit)
      CSD_P1: begin
        q_next  = {q[W-1:0], 1'b1};
        qm_next = {q[W-1:0], 1'b0};
      end
      CSD_M1: begin
        q_next  = {qm[W-1:0], 1'b1};
        qm_next = {qm[W-1:0], 1'b0};
      end
      default: begin
        q_next  = {q[W-1:0], 1'b0};
        qm_next = {qm[W-1:0], 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/csd2bin_serial.sv
// Digit-serial CSD to two's complement converter, MSD first, with
// valid/ready handshake on both sides and per-word error flags.
module csd2bin_serial
  import csd2bin_serial_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_digit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_y,
  output logic         out_err_ill,
  output logic         out_err_ncan
);

  localparam int unsigned CW      = $clog2(W + 1);
  localparam logic [CW-1:0] LAST  = CW'(W - 1);
  localparam logic [W:0]    Q_INIT  = '0;
  localparam logic [W:0]    QM_INIT = '1;

  state_t        state_q, state_d;
  logic [W:0]    q_q, q_d, qm_q, qm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_nz_q, prev_nz_d;
  logic          ill_q, ill_d, ncan_q, ncan_d;
  logic          out_valid_d, out_err_ill_d, out_err_ncan_d;
  logic [W:0]    out_y_d;

  logic [W:0]    step_q, step_qm;
  logic          take, digit_nz, ill_nx, ncan_nx;

  csd_otf_step #(.W(W)) u_step (
    .q       (q_q),
    .qm      (qm_q),
    .digit   (in_digit),
    .q_next  (step_q),
    .qm_next (step_qm)
  );

  // Ready while accumulating, or while holding if the word leaves this cycle
  assign in_ready = (state_q == ST_ACCUM) || ((state_q == ST_HOLD) && out_ready);
  assign take     = in_valid && in_ready;
  assign digit_nz = csd_is_nz(in_digit);
  assign ill_nx   = ill_q | (in_digit == CSD_ILL);
  assign ncan_nx  = ncan_q | (digit_nz & prev_nz_q);

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d        = state_q;
    q_d            = q_q;
    qm_d           = qm_q;
    cnt_d          = cnt_q;
    prev_nz_d      = prev_nz_q;
    ill_d          = ill_q;
    ncan_d         = ncan_q;
    out_valid_d    = out_valid;
    out_y_d        = out_y;
    out_err_ill_d  = out_err_ill;
    out_err_ncan_d = out_err_ncan;

    if ((state_q == ST_HOLD) && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ST_ACCUM;
    end

    if (take) begin
      if (cnt_q == LAST) begin
        out_y_d        = step_q;
        out_err_ill_d  = ill_nx;
        out_err_ncan_d = ncan_nx;
        out_valid_d    = 1'b1;
        state_d        = ST_HOLD;
        q_d            = Q_INIT;
        qm_d           = QM_INIT;
        cnt_d          = '0;
        prev_nz_d      = 1'b0;
        ill_d          = 1'b0;
        ncan_d         = 1'b0;
      end else begin
        q_d       = step_q;
        qm_d      = step_qm;
        cnt_d     = cnt_q + CW'(1);
        prev_nz_d = digit_nz;
        ill_d     = ill_nx;
        ncan_d    = ncan_nx;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      q_q          <= Q_INIT;
      qm_q         <= QM_INIT;
      cnt_q        <= '0;
      prev_nz_q    <= 1'b0;
      ill_q        <= 1'b0;
      ncan_q       <= 1'b0;
      out_valid    <= 1'b0;
      out_y        <= '0;
      out_err_ill  <= 1'b0;
      out_err_ncan <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_q          <= q_d;
      qm_q         <= qm_d;
      cnt_q        <= cnt_d;
      prev_nz_q    <= prev_nz_d;
      ill_q        <= ill_d;
      ncan_q       <= ncan_d;
      out_valid    <= out_valid_d;
      out_y        <= out_y_d;
      out_err_ill  <= out_err_ill_d;
      out_err_ncan <= out_err_ncan_d;
    end
  end

endmodule

// File: tb/tb_csd2bin_serial.sv
// Bench for csd2bin_serial: directed and random digit streams checked
// against an arithmetic model of the CSD word value and flags.
module tb_csd2bin_serial;

  localparam int unsigned W = 5;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] M = 2'b10;
  localparam logic [1:0] I = 2'b11;

  typedef struct {
    logic [W:0] y;
    logic       ill;
    logic       ncan;
  } exp_t;

  typedef logic [1:0] word_t [W];

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_digit;
  logic       out_valid;
  logic       out_ready;
  logic [W:0] out_y;
  logic       out_err_ill;
  logic       out_err_ncan;

  int checks = 0;
  int passed = 0;

  exp_t       expq[$];
  logic [1:0] cur[$];

  always #5 clk = ~clk;

  csd2bin_serial #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_digit     (in_digit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
    .out_err_ill  (out_err_ill),
    .out_err_ncan (out_err_ncan)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Value of the collected word as a plain signed sum, plus its error flags
  function automatic exp_t model_word();
    exp_t e;
    int   val;
    int   dv;
    logic pnz;
    val = 0; pnz = 1'b0; e.ill = 1'b0; e.ncan = 1'b0;
    foreach (cur[i]) begin
      dv = (cur[i] == P) ? 1 : (cur[i] == M) ? -1 : 0;
      if (cur[i] == I) e.ill = 1'b1;
      if (dv != 0 && pnz) e.ncan = 1'b1;
      pnz = (dv != 0);
      val = val * 2 + dv;
    end
    e.y = (W+1)'(val);
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, check mid-cycle, update the model
  task automatic step(input logic v, input logic [1:0] d, input logic ordy);
    logic hold;
    logic er;
    exp_t e;
    in_valid = v; in_digit = d; out_ready = ordy;
    #1;
    hold = (expq.size() != 0);
    er   = !hold || ordy;
    check("out_valid", 32'(out_valid), 32'(hold));
    check("in_ready", 32'(in_ready), 32'(er));
    if (hold) begin
      e = expq[0];
      check("out_y", 32'(out_y), 32'(e.y));
      check("out_err_ill", 32'(out_err_ill), 32'(e.ill));
      check("out_err_ncan", 32'(out_err_ncan), 32'(e.ncan));
      if (ordy) void'(expq.pop_front());
    end
    if (v && er) begin
      cur.push_back(d);
      if (cur.size() == W) begin
        expq.push_back(model_word());
        cur.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic send_word(input word_t w, input logic ordy);
    for (int i = 0; i < int'(W); i++) step(1'b1, w[i], ordy);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_digit = Z; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    cur.delete();
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_flags", 32'({out_err_ill, out_err_ncan}), 32'd0);
  endtask

  initial begin
    word_t w;
    int    n;
    int    dv;
    int    r;
    logic [1:0] dg;

    rst = 1'b1; in_valid = 1'b0; in_digit = Z; out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // +6, then drain
    w = '{Z, P, Z, M, Z}; send_word(w, 1'b1);
    step(1'b0, Z, 1'b1);

    // Back-to-back words: -5, +21, -21
    w = '{Z, Z, M, Z, M}; send_word(w, 1'b1);
    w = '{P, Z, P, Z, P}; send_word(w, 1'b1);
    w = '{M, Z, M, Z, M}; send_word(w, 1'b1);
    step(1'b0, Z, 1'b1);

    // Non-canonical word, then a clean word to show flags clear
    w = '{P, P, Z, Z, Z}; send_word(w, 1'b1);
    w = '{Z, Z, Z, Z, P}; send_word(w, 1'b1);
    step(1'b0, Z, 1'b1);

    // Illegal digit
    w = '{Z, I, Z, Z, P}; send_word(w, 1'b1);
    step(1'b0, Z, 1'b1);

    // Consumer stall for 7 cycles, then accept together with a new MSD
    w = '{P, Z, M, Z, P}; send_word(w, 1'b0);
    repeat (7) step(1'b1, M, 1'b0);
    step(1'b1, P, 1'b1);
    for (int i = 0; i < int'(W) - 1; i++) step(1'b1, Z, 1'b1);
    step(1'b0, Z, 1'b1);

    // Reset after the third digit discards the partial word
    step(1'b1, P, 1'b1);
    step(1'b1, Z, 1'b1);
    step(1'b1, M, 1'b1);
    do_reset();
    w = '{M, Z, Z, P, Z}; send_word(w, 1'b1);
    step(1'b0, Z, 1'b1);

    // Loopback of every 5-bit two's complement value through its NAF digits
    for (int x = -16; x < 16; x++) begin
      n = x;
      for (int k = int'(W) - 1; k >= 0; k--) begin
        if ((n % 2) != 0) begin
          r  = ((n % 4) + 4) % 4;
          dv = (r == 1) ? 1 : -1;
        end else begin
          dv = 0;
        end
        n = (n - dv) / 2;
        w[k] = (dv == 1) ? P : (dv == -1) ? M : Z;
      end
      send_word(w, 1'b1);
    end
    step(1'b0, Z, 1'b1);

    // Random digits with input gaps and consumer stalls
    for (int t = 0; t < 300; t++) begin
      r  = int'($urandom_range(0, 15));
      dg = (r < 6) ? Z : (r < 11) ? P : (r < 15) ? M : I;
      step(($urandom_range(0, 3) != 0), dg, ($urandom_range(0, 3) != 0));
    end
    repeat (3) step(1'b0, Z, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
